// File: rtl/l4_expand_ctrl_pkg.sv
// Shared L4 declarations: array command and cell codes, controller states,
// and the per-state array control word.
package l4_expand_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_CLEARX = 2'b00,
        CMD_WRITE  = 2'b01,
        CMD_EXPAND = 2'b10,
        CMD_READ   = 2'b11
    } l4_cmd_e;

    typedef enum logic [1:0] {
        CELL_FREE     = 2'b00,
        CELL_BLOCKED  = 2'b01,
        CELL_EXPANDED = 2'b10,
        CELL_TARGET   = 2'b11
    } l4_cell_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_HEXP,
        S_VSWEEP,
        S_CHECK,
        S_FIN
    } ctrl_state_e;

    typedef struct packed {
        l4_cmd_e cmd;
        logic    pref_ew;
        logic    pref_ns;
        logic    pref_ud;
        logic    busy;
        logic    done;
    } arr_ctl_t;

    // Array-facing control word presented while the FSM sits in state s.
    function automatic arr_ctl_t ctl_of(input ctrl_state_e s);
        arr_ctl_t c;
        c = '{cmd: CMD_READ, pref_ew: 1'b0, pref_ns: 1'b0, pref_ud: 1'b0,
              busy: 1'b0, done: 1'b0};
        case (s)
            S_CLR: begin
                c.cmd  = CMD_CLEARX;
                c.busy = 1'b1;
            end
            S_HEXP: begin
                c.cmd     = CMD_EXPAND;
                c.pref_ew = 1'b1;
                c.pref_ns = 1'b1;
                c.busy    = 1'b1;
            end
            S_VSWEEP: begin
                c.cmd     = CMD_EXPAND;
                c.pref_ud = 1'b1;
                c.busy    = 1'b1;
            end
            S_CHECK: c.busy = 1'b1;
            S_FIN:   c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/l4_expand_ctrl_sweep_cnt.sv
// Layer-sweep counter: counts consecutive enabled cycles modulo NLAYERS and
// flags the last one so the layer ring always completes a full revolution.
module l4_expand_ctrl_sweep_cnt #(
    parameter int NLAYERS = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = (NLAYERS > 1) ? $clog2(NLAYERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NLAYERS - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = i_en && (r_cnt == LAST);

endmodule

// File: rtl/l4_expand_ctrl.sv
// L4 wavefront expansion controller: sequences clear, horizontal expand and
// full vertical layer sweeps, with an optional etch retry pass.
module l4_expand_ctrl
    import l4_expand_ctrl_pkg::*;
#(
    parameter int NLAYERS = 8,
    parameter int STEPW   = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_etch_ok,
    input  logic             i_ext_mode,
    input  logic [STEPW-1:0] i_max_steps,
    input  logic             i_exp_n,
    input  logic             i_hit_n,
    output logic [1:0]       o_cmd,
    output logic             o_pref_ew,
    output logic             o_pref_ns,
    output logic             o_pref_ud,
    output logic             o_etch_enb,
    output logic             o_extend,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_found,
    output logic             o_fail,
    output logic [STEPW-1:0] o_steps
);

    ctrl_state_e      r_state;
    arr_ctl_t         r_ctl;
    logic             r_etch_enb, r_found, r_fail;
    logic             r_etch_ok, r_ext_mode;
    logic             r_any_exp, r_hit, r_abort;
    logic [STEPW-1:0] r_steps, r_max_steps;
    logic [STEPW-1:0] w_steps_inc;
    logic             w_sweep_en, w_tc;

    function automatic logic [STEPW-1:0] sat_inc(input logic [STEPW-1:0] v);
        return (&v) ? v : v + STEPW'(1);
    endfunction

    assign w_sweep_en  = (r_state == S_VSWEEP);
    assign w_steps_inc = sat_inc(r_steps);

    l4_expand_ctrl_sweep_cnt #(.NLAYERS(NLAYERS)) u_sweep (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (w_sweep_en),
        .o_tc   (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ctl       <= ctl_of(S_IDLE);
            r_etch_enb  <= 1'b0;
            r_found     <= 1'b0;
            r_fail      <= 1'b0;
            r_etch_ok   <= 1'b0;
            r_ext_mode  <= 1'b0;
            r_any_exp   <= 1'b0;
            r_hit       <= 1'b0;
            r_abort     <= 1'b0;
            r_steps     <= '0;
            r_max_steps <= '0;
        end else begin
            if (r_state == S_HEXP || r_state == S_VSWEEP) begin
                if (!i_exp_n) r_any_exp <= 1'b1;
                if (!i_hit_n) r_hit <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_etch_ok   <= i_etch_ok;
                        r_ext_mode  <= i_ext_mode;
                        r_max_steps <= i_max_steps;
                        r_steps     <= '0;
                        r_etch_enb  <= 1'b0;
                        r_found     <= 1'b0;
                        r_any_exp   <= 1'b0;
                        r_hit       <= 1'b0;
                        r_abort     <= 1'b0;
                        // A zero step budget can never be met: fail without touching the array.
                        if (i_max_steps == '0) begin
                            r_state <= S_FIN;
                            r_ctl   <= ctl_of(S_FIN);
                            r_fail  <= 1'b1;
                        end else begin
                            r_state <= S_CLR;
                            r_ctl   <= ctl_of(S_CLR);
                            r_fail  <= 1'b0;
                        end
                    end
                end
                S_CLR: begin
                    if (i_abort) begin
                        r_state <= S_FIN;  r_ctl  <= ctl_of(S_FIN);
                        r_etch_enb <= 1'b0; r_fail <= 1'b1;
                    end else begin
                        r_state   <= S_HEXP;
                        r_ctl     <= ctl_of(S_HEXP);
                        r_any_exp <= 1'b0;
                    end
                end
                S_HEXP: begin
                    if (i_abort) begin
                        r_state <= S_FIN;  r_ctl  <= ctl_of(S_FIN);
                        r_etch_enb <= 1'b0; r_fail <= 1'b1;
                    end else begin
                        r_state <= S_VSWEEP;
                        r_ctl   <= ctl_of(S_VSWEEP);
                    end
                end
                S_VSWEEP: begin
                    // Abort and hit only take effect once the ring is back in alignment.
                    if (i_abort) r_abort <= 1'b1;
                    if (w_tc) begin
                        if (r_abort || i_abort) begin
                            r_state <= S_FIN;  r_ctl  <= ctl_of(S_FIN);
                            r_etch_enb <= 1'b0; r_fail <= 1'b1;
                        end else if (r_hit || !i_hit_n) begin
                            r_state <= S_FIN;  r_ctl   <= ctl_of(S_FIN);
                            r_etch_enb <= 1'b0; r_found <= 1'b1;
                        end else begin
                            r_state <= S_CHECK;
                            r_ctl   <= ctl_of(S_CHECK);
                        end
                    end
                end
                S_CHECK: begin
                    if (i_abort) begin
                        r_state <= S_FIN;  r_ctl  <= ctl_of(S_FIN);
                        r_etch_enb <= 1'b0; r_fail <= 1'b1;
                    end else if (!r_any_exp || w_steps_inc >= r_max_steps) begin
                        if (r_etch_ok && !r_etch_enb) begin
                            r_etch_enb <= 1'b1;
                            r_steps    <= '0;
                            r_state    <= S_CLR;
                            r_ctl      <= ctl_of(S_CLR);
                        end else begin
                            r_steps <= w_steps_inc;
                            r_state <= S_FIN;  r_ctl  <= ctl_of(S_FIN);
                            r_etch_enb <= 1'b0; r_fail <= 1'b1;
                        end
                    end else begin
                        r_steps   <= w_steps_inc;
                        r_any_exp <= 1'b0;
                        r_state   <= S_HEXP;
                        r_ctl     <= ctl_of(S_HEXP);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_ctl   <= ctl_of(S_IDLE);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ctl   <= ctl_of(S_IDLE);
                end
            endcase
        end
    end

    assign o_cmd      = r_ctl.cmd;
    assign o_pref_ew  = r_ctl.pref_ew;
    assign o_pref_ns  = r_ctl.pref_ns;
    assign o_pref_ud  = r_ctl.pref_ud;
    assign o_busy     = r_ctl.busy;
    assign o_done     = r_ctl.done;
    assign o_etch_enb = r_etch_enb;
    assign o_extend   = r_ctl.busy & r_ext_mode;
    assign o_found    = r_found;
    assign o_fail     = r_fail;
    assign o_steps    = r_steps;

endmodule

// File: tb/tb_l4_expand_ctrl.sv
// Scoreboard bench for l4_expand_ctrl: directed routes push expected outcomes,
// a monitor tallies array commands per route and checks them at done.
module tb_l4_expand_ctrl;
    import l4_expand_ctrl_pkg::*;

    localparam int NLAYERS = 8;
    localparam int STEPW   = 10;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic             i_etch_ok = 1'b0;
    logic             i_ext_mode = 1'b0;
    logic [STEPW-1:0] i_max_steps = '0;
    logic             i_exp_n = 1'b1;
    logic             i_hit_n = 1'b1;
    logic [1:0]       o_cmd;
    logic             o_pref_ew, o_pref_ns, o_pref_ud, o_etch_enb, o_extend;
    logic             o_busy, o_done, o_found, o_fail;
    logic [STEPW-1:0] o_steps;

    l4_expand_ctrl #(.NLAYERS(NLAYERS), .STEPW(STEPW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_etch_ok(i_etch_ok), .i_ext_mode(i_ext_mode), .i_max_steps(i_max_steps),
        .i_exp_n(i_exp_n), .i_hit_n(i_hit_n), .o_cmd(o_cmd),
        .o_pref_ew(o_pref_ew), .o_pref_ns(o_pref_ns), .o_pref_ud(o_pref_ud),
        .o_etch_enb(o_etch_enb), .o_extend(o_extend), .o_busy(o_busy),
        .o_done(o_done), .o_found(o_found), .o_fail(o_fail), .o_steps(o_steps)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int found; int fail; int steps;
        int n_exp; int n_ud; int n_clr; int n_etch; int n_ext;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_err = 0;
    string cur_test = "init";

    // Array model knobs for the current route.
    logic cfg_exp_n = 1'b1;
    int   cfg_hit_at = 0;
    int   cfg_abort_ud = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input int f, input int fl, input int st, input int ne,
                                input int nu, input int nc, input int net, input int nx);
        exp_t e;
        e.found = f; e.fail = fl; e.steps = st; e.n_exp = ne;
        e.n_ud = nu; e.n_clr = nc; e.n_etch = net; e.n_ext = nx;
        return e;
    endfunction

    // Array stand-in: answers exp_n/hit_n per EXPAND cycle, raises abort on a chosen sweep cycle.
    int d_exp = 0;
    int d_ud = 0;
    always @(negedge i_clk) begin
        if (!o_busy) begin
            d_exp = 0; d_ud = 0;
            i_exp_n = 1'b1; i_hit_n = 1'b1; i_abort = 1'b0;
        end else begin
            if (o_cmd == CMD_EXPAND) begin
                d_exp++;
                i_exp_n = cfg_exp_n;
                i_hit_n = (d_exp == cfg_hit_at) ? 1'b0 : 1'b1;
            end else begin
                i_exp_n = 1'b1; i_hit_n = 1'b1;
            end
            if (o_pref_ud) begin
                d_ud++;
                if (cfg_abort_ud != 0 && d_ud >= cfg_abort_ud) i_abort = 1'b1;
            end
        end
    end

    // Monitor: tallies commands during a route, compares against scoreboard at done.
    int   m_exp = 0, m_ud = 0, m_clr = 0, m_etch = 0, m_ext = 0;
    exp_t m_e;
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            m_exp = 0; m_ud = 0; m_clr = 0; m_etch = 0; m_ext = 0;
        end else begin
            if (o_cmd == CMD_EXPAND) m_exp++;
            if (o_pref_ud) m_ud++;
            if (o_cmd == CMD_CLEARX) m_clr++;
            if (o_cmd == CMD_EXPAND && o_etch_enb) m_etch++;
            if (o_extend) m_ext++;
            if (o_done) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("%s.unexpected_done", cur_test), 1, 0);
                end else begin
                    m_e = sb_q.pop_front();
                    chk($sformatf("%s.found", cur_test), int'(o_found), m_e.found);
                    chk($sformatf("%s.fail", cur_test), int'(o_fail), m_e.fail);
                    chk($sformatf("%s.steps", cur_test), int'(o_steps), m_e.steps);
                    chk($sformatf("%s.expand_cycles", cur_test), m_exp, m_e.n_exp);
                    chk($sformatf("%s.ud_cycles", cur_test), m_ud, m_e.n_ud);
                    chk($sformatf("%s.clearx_cycles", cur_test), m_clr, m_e.n_clr);
                    chk($sformatf("%s.etch_expand_cycles", cur_test), m_etch, m_e.n_etch);
                    chk($sformatf("%s.extend_cycles", cur_test), m_ext, m_e.n_ext);
                end
                m_exp = 0; m_ud = 0; m_clr = 0; m_etch = 0; m_ext = 0;
            end
        end
    end

    task automatic check_idle_outputs(input string nm);
        chk({nm, ".cmd"}, int'(o_cmd), int'(CMD_READ));
        chk({nm, ".flags"}, int'({o_pref_ew, o_pref_ns, o_pref_ud, o_etch_enb,
                                  o_extend, o_busy, o_done, o_found, o_fail}), 0);
        chk({nm, ".steps"}, int'(o_steps), 0);
    endtask

    task automatic run_route(input string nm, input logic etch, input logic ext,
                             input int maxs, input logic expn, input int hit_at,
                             input int ab_ud, input exp_t e,
                             input bit start_mid, input bit start_on_done);
        bit   got;
        exp_t tmp;
        got = 1'b0;
        cur_test = nm;
        cfg_exp_n = expn; cfg_hit_at = hit_at; cfg_abort_ud = ab_ud;
        sb_q.push_back(e);
        @(negedge i_clk);
        i_etch_ok = etch; i_ext_mode = ext; i_max_steps = STEPW'(maxs); i_start = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge i_clk);
            // Changing inputs after start must not affect the route.
            i_etch_ok = ~etch; i_ext_mode = ~ext; i_max_steps = STEPW'(1);
            if (o_done) begin
                got = 1'b1;
                break;
            end
            i_start = start_mid && (c == 6);
        end
        if (!got) begin
            i_start = 1'b0;
            chk({nm, ".done_timeout"}, 0, 1);
            tmp = sb_q.pop_back();
        end else begin
            i_start = start_on_done;
            @(negedge i_clk);
            i_start = 1'b0;
            @(negedge i_clk);
            chk({nm, ".idle_after_done"}, int'(o_busy), 0);
            chk({nm, ".found_held"}, int'(o_found), e.found);
            chk({nm, ".fail_held"}, int'(o_fail), e.fail);
            chk({nm, ".steps_held"}, int'(o_steps), e.steps);
        end
        i_etch_ok = 1'b0; i_ext_mode = 1'b0; i_max_steps = '0;
    endtask

    initial begin
        bit hexp_seen;
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        check_idle_outputs("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // nm, etch, ext, max, exp_n, hit_at, abort_ud, expected, start_mid, start_on_done
        run_route("hit_3rd_expand", 1'b0, 1'b1, 100, 1'b0, 3, 0,
                  mk(1, 0, 0, 9, 8, 1, 0, 10), 1'b0, 1'b0);
        run_route("no_expand_fail", 1'b0, 1'b0, 100, 1'b1, 0, 0,
                  mk(0, 1, 1, 9, 8, 1, 0, 0), 1'b0, 1'b1);
        run_route("etch_retry", 1'b1, 1'b1, 100, 1'b1, 0, 0,
                  mk(0, 1, 1, 18, 16, 2, 9, 22), 1'b0, 1'b0);
        run_route("step_limit3", 1'b0, 1'b1, 3, 1'b0, 0, 0,
                  mk(0, 1, 3, 27, 24, 1, 0, 31), 1'b1, 1'b0);
        run_route("abort_vsweep2", 1'b0, 1'b0, 100, 1'b0, 0, 2,
                  mk(0, 1, 0, 9, 8, 1, 0, 0), 1'b0, 1'b0);
        run_route("max_zero", 1'b0, 1'b1, 0, 1'b0, 0, 0,
                  mk(0, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        run_route("hit_in_hexp", 1'b0, 1'b1, 100, 1'b1, 1, 0,
                  mk(1, 0, 0, 9, 8, 1, 0, 10), 1'b0, 1'b0);

        // Asynchronous reset while the horizontal expand is on the array.
        cur_test = "reset_mid";
        cfg_exp_n = 1'b1; cfg_hit_at = 0; cfg_abort_ud = 0;
        @(negedge i_clk);
        i_max_steps = STEPW'(100); i_ext_mode = 1'b1; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        hexp_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (o_cmd == CMD_EXPAND && o_pref_ew) begin
                hexp_seen = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        chk("reset_mid.reach_hexp", int'(hexp_seen), 1);
        #2 i_rst_n = 1'b0;
        #1 check_idle_outputs("reset_mid_async");
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        i_max_steps = '0; i_ext_mode = 1'b0;
        @(negedge i_clk);
        chk("reset_mid.idle_after_release", int'(o_busy), 0);

        run_route("after_reset", 1'b0, 1'b0, 100, 1'b1, 0, 0,
                  mk(0, 1, 1, 9, 8, 1, 0, 0), 1'b0, 1'b0);

        repeat (3) @(negedge i_clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached in %s", cur_test);
        $fatal(1, "watchdog");
    end

endmodule
